uart_tx_arbiter: RTL

//  Shares one uart_tx serialiser between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx handshake bundle for uart_tx_arbiter.
// slave is the arbiter view; master drives requests and uart_tx busy.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]              req_last;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            uart_tx_en;
    logic [PAYLOAD_BITS-1:0]         uart_tx_data;
    logic                            uart_tx_busy;

    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, uart_tx_en, uart_tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, uart_tx_en, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx serialiser
// between NUM_REQ byte-stream requesters, with optional inter-frame gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int GAP_CYCLES   = 0,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic [IDX_W-1:0] grant_id,
    output logic             locked
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    localparam logic [15:0] GAP_LOAD =
        16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [15:0]      gap_cnt;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] nxt_ptr;
    logic             pick_ok;
    logic             can_pick;
    int               j;

    // Lowest offset from rr_ptr wins, so scan from the far end down.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = grant_id;
        j        = 0;
        if (locked) begin
            pick_ok = bus.req_valid[grant_id];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (bus.req_valid[IDX_W'(j)]) begin
                    pick_ok  = 1'b1;
                    pick_idx = IDX_W'(j);
                end
            end
        end
    end

    assign can_pick = (state == IDLE) && !bus.uart_tx_busy
                    && pick_ok && !rst;

    assign nxt_ptr = (pick_idx == IDX_W'(NUM_REQ - 1))
                   ? '0 : pick_idx + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (can_pick) bus.req_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            gap_cnt          <= '0;
            grant_id         <= '0;
            locked           <= 1'b0;
            bus.uart_tx_en   <= 1'b0;
            bus.uart_tx_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (can_pick) begin
                        bus.uart_tx_data <= bus.req_data[
                            pick_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
                        grant_id       <= pick_idx;
                        locked         <= ~bus.req_last[pick_idx];
                        bus.uart_tx_en <= 1'b1;
                        state          <= ISSUE;
                        if (bus.req_last[pick_idx]) rr_ptr <= nxt_ptr;
                    end
                end
                ISSUE: begin
                    bus.uart_tx_en <= 1'b0;
                    state          <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.uart_tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!bus.uart_tx_busy) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) state <= IDLE;
                    else gap_cnt <= gap_cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
